// File: rtl/merge_packer.sv
// merge_packer: packs up to LANES variable-length, right-aligned lanes per beat into MSB-first OUT_WIDTH-bit words.
// Optional counters stat_words/stat_bits are built when MERGE_PACKER_STATS_EN is defined.
module merge_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 6,
  parameter int LANES      = 2,
  parameter int OUT_WIDTH  = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   in_data,
  input  logic [LANES*LEN_WIDTH-1:0]    in_len,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic [$clog2(OUT_WIDTH):0]    out_bits,
  output logic                          out_last
`ifdef MERGE_PACKER_STATS_EN
  ,
  output logic [31:0]                   stat_words,
  output logic [31:0]                   stat_bits
`endif
);

  localparam int CAT_W  = LANES * DATA_WIDTH;
  localparam int ACC_W  = OUT_WIDTH + CAT_W;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam int OB_W   = $clog2(OUT_WIDTH) + 1;

  typedef enum logic {ACCUM = 1'b0, FLUSH = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic                  out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]  out_data_q, out_data_d;
  logic [OB_W-1:0]       out_bits_q, out_bits_d;
  logic                  out_last_q, out_last_d;

  logic [CAT_W-1:0]      cat_s, cat_al_s;
  logic [FILL_W-1:0]     total_s, lane_bits_s;
  logic [LEN_WIDTH-1:0]  lane_len_s;
  logic [DATA_WIDTH-1:0] lane_data_s;
  logic [ACC_W-1:0]      ins_s;
  logic                  accept_s, can_load_s, full_s;

  assign full_s     = (fill_q >= FILL_W'(OUT_WIDTH));
  assign in_ready   = reset & (state_q == ACCUM) & ~full_s;
  assign accept_s   = in_valid & in_ready;
  assign can_load_s = ~out_valid_q | out_ready;

  // Lane concatenation: clamp, mask, append lane 0 first, then MSB-align below the current fill.
  always_comb begin
    cat_s       = '0;
    total_s     = '0;
    lane_len_s  = '0;
    lane_bits_s = '0;
    lane_data_s = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_len_s  = in_len[(LANES-1-i)*LEN_WIDTH +: LEN_WIDTH];
      lane_data_s = in_data[(LANES-1-i)*DATA_WIDTH +: DATA_WIDTH];
      if (lane_len_s > LEN_WIDTH'(DATA_WIDTH)) begin
        lane_bits_s = FILL_W'(DATA_WIDTH);
      end else begin
        lane_bits_s = FILL_W'(lane_len_s);
      end
      cat_s   = (cat_s << lane_bits_s) |
                CAT_W'(lane_data_s & ~({DATA_WIDTH{1'b1}} << lane_bits_s));
      total_s = total_s + lane_bits_s;
    end
    cat_al_s = cat_s << (FILL_W'(CAT_W) - total_s);
    ins_s    = {cat_al_s, {OUT_WIDTH{1'b0}}} >> fill_q;
  end

  // Next state: word load (full or flush residual) has priority; beats only land in ACCUM below a full word.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    fill_d      = fill_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_data_d  = out_data_q;
    out_bits_d  = out_bits_q;
    out_last_d  = out_last_q;
    if (full_s && can_load_s) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_q[ACC_W-1 -: OUT_WIDTH];
      out_bits_d  = OB_W'(OUT_WIDTH);
      acc_d       = acc_q << OUT_WIDTH;
      fill_d      = fill_q - FILL_W'(OUT_WIDTH);
      out_last_d  = (state_q == FLUSH) && (fill_q == FILL_W'(OUT_WIDTH));
      if (out_last_d) begin
        state_d = ACCUM;
      end else begin
        state_d = state_q;
      end
    end else if ((state_q == FLUSH) && can_load_s) begin
      // Residual is already left-aligned and zero below fill; fill=0 yields the empty terminator word.
      out_valid_d = 1'b1;
      out_data_d  = acc_q[ACC_W-1 -: OUT_WIDTH];
      out_bits_d  = OB_W'(fill_q);
      out_last_d  = 1'b1;
      acc_d       = '0;
      fill_d      = '0;
      state_d     = ACCUM;
    end else if (accept_s) begin
      acc_d  = acc_q | ins_s;
      fill_d = fill_q + total_s;
      if (in_last) begin
        state_d = FLUSH;
      end else begin
        state_d = ACCUM;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_bits_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_bits_q  <= out_bits_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_bits  = out_bits_q;
  assign out_last  = out_last_q;

`ifdef MERGE_PACKER_STATS_EN
  logic [31:0] stat_words_q, stat_bits_q;

  // Free-running wrap-around counters of delivered words and accepted bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_words_q <= 32'd0;
      stat_bits_q  <= 32'd0;
    end else begin
      if (out_valid_q && out_ready) begin
        stat_words_q <= stat_words_q + 32'd1;
      end
      if (accept_s) begin
        stat_bits_q <= stat_bits_q + 32'(total_s);
      end
    end
  end

  assign stat_words = stat_words_q;
  assign stat_bits  = stat_bits_q;
`endif

endmodule

// File: doc/merge_packer.md
MERGE_PACKER -- requirements
Module: merge_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of one input lane.
REQ-002 SHALL have parameter LEN_WIDTH, default 6: width of each lane length field, in bits, covering 0..DATA_WIDTH.
REQ-003 SHALL have parameter LANES, default 2, legal 1..4: input lanes merged per beat.
REQ-004 SHALL have parameter OUT_WIDTH, default 64: output word width; OUT_WIDTH >= LANES*DATA_WIDTH.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have ports in_valid (input, 1) and in_ready (output, 1): input beat handshake.
REQ-008 SHALL have port in_data, input, LANES*DATA_WIDTH bits: lane 0 in the most-significant slice; each lane's payload is right-aligned.
REQ-009 SHALL have port in_len, input, LANES*LEN_WIDTH bits: valid bit count per lane; lane 0 in the most-significant slice.
REQ-010 SHALL have port in_last, input, 1 bit: marks the final beat of a stream.
REQ-011 SHALL have ports out_valid (output, 1) and out_ready (input, 1): output word handshake.
REQ-012 SHALL have port out_data, output, OUT_WIDTH bits: packed word, first bit at the MSB.
REQ-013 SHALL have port out_bits, output, clog2(OUT_WIDTH)+1 bits: valid bits in out_data.
REQ-014 SHALL have port out_last, output, 1 bit: marks the final word of a stream.

Function
REQ-015 SHALL accept a beat on a rising edge with in_valid=1 and in_ready=1, and only then.
REQ-016 SHALL concatenate lanes in the order lane 0 first, keeping only the low in_len bits of each lane; in_len > DATA_WIDTH SHALL be clamped to DATA_WIDTH; bits above in_len SHALL be masked.
REQ-017 SHALL append the concatenated bits to an accumulator of OUT_WIDTH+LANES*DATA_WIDTH bits, directly below the existing fill.
REQ-018 SHALL drive in_ready=1 only when state is ACCUM and fill < OUT_WIDTH.
REQ-019 SHALL move the top OUT_WIDTH accumulator bits into the output register when fill >= OUT_WIDTH and (out_valid=0 or out_ready=1); fill SHALL then decrease by OUT_WIDTH and the remainder SHALL shift up; out_bits SHALL equal OUT_WIDTH.
REQ-020 Latency: a word completed by a beat accepted on edge E SHALL first show out_valid=1 after edge E+1.
REQ-021 SHALL hold out_data, out_bits and out_last stable while out_valid=1 and out_ready=0.
REQ-022 SHALL implement states ACCUM and FLUSH; ACCUM->FLUSH on acceptance of a beat with in_last=1; FLUSH->ACCUM when the word carrying out_last=1 is loaded.
REQ-023 In FLUSH, full words SHALL drain per REQ-019; a word that leaves fill=0 SHALL carry out_last=1.
REQ-024 In FLUSH with 0 < fill < OUT_WIDTH, SHALL emit one word: residual bits left-aligned, zero-padded, out_bits=fill, out_last=1.
REQ-025 In FLUSH with fill=0 and no full word pending, SHALL emit one word with out_data=0, out_bits=0, out_last=1.
REQ-026 A beat with every in_len=0 and in_last=0 SHALL be accepted and leave the accumulator unchanged.

Reset
REQ-027 While reset=0, SHALL hold out_valid=0, out_data=0, out_bits=0, out_last=0, in_ready=0, fill=0, and state ACCUM, regardless of clk.
REQ-028 Reset asserted mid-stream SHALL discard accumulator contents and any pending output word; in_ready SHALL be 1 on the first edge after reset deasserts.

Configuration
REQ-029 With MERGE_PACKER_STATS_EN defined, SHALL add 32-bit outputs stat_words (words handshaken out) and stat_bits (bits accepted); both reset to 0 and wrap modulo 2^32.
REQ-030 Without MERGE_PACKER_STATS_EN, SHALL have neither the stat ports nor their counters, with identical datapath behaviour.

Verification (DATA_WIDTH=32, LANES=2, OUT_WIDTH=64)
REQ-031 Reset pulse mid-stream with fill=40 -> all outputs 0 during reset; in_ready=1 one edge after release; the next word contains no old bits.
REQ-032 Beat lanes 0xAAAAAAAA/32 and 0x55555555/32 -> out_data=0xAAAAAAAA55555555, out_bits=64, out_valid one edge after acceptance; in_ready=0 for exactly one cycle.
REQ-033 Beat lanes 0x5/3 and 0x3/2 with in_last=1 -> out_data=0xB800000000000000, out_bits=5, out_last=1.
REQ-034 Two full words pending with out_ready=0 for 5 cycles -> out_data stable, in_ready=0; both words delivered in order after out_ready=1.
REQ-035 Lane 0 0xFFFFFFFF with in_len=40, lane 1 in_len=0, then an in_last beat with all in_len=0 -> out_bits=32 (clamped), out_data=0xFFFFFFFF00000000, out_last=1.
REQ-036 With MERGE_PACKER_STATS_EN, stat_words preloaded by force to 0xFFFFFFFF plus one word out -> stat_words=0.
